mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port RAM arbiter between the instruction cache and the data cache. Both caches raise blocking requests toward memory; this block grants one at a time with round-robin fairness, drives the shared RAM port, and returns per-requester wait/load. It sits between the two caches and the RAM model, inside the caches/memory-control hierarchy.

## Interface
Parameters:
- ADDR_W, 32, address width (word_t)
- DATA_W, 32, data width
- TIMEOUT, 255, maximum cycles a grant may wait for ACCESS before abort

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset; one clock, reset is asynchronous and active-high
- iREN  in  1  icache read request
- iaddr  in  ADDR_W  icache address
- iwait  out  1  low for exactly the completing cycle of an icache read
- iload  out  DATA_W  icache read data (valid when iwait low)
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  ADDR_W  dcache address
- dstore  in  DATA_W  dcache write data
- dwait  out  1  low for exactly the completing cycle of a dcache access
- dload  out  DATA_W  dcache read data (valid when dwait low)
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  ramstate_t: FREE=0, BUSY=1, ACCESS=2, ERROR=3
- arb_err  out  1  one-cycle pulse on RAM ERROR or timeout abort

## Operation
- States: ARB_IDLE, ARB_I (icache granted), ARB_D (dcache granted).
- ARB_IDLE: dreq = dREN|dWEN. Only one requests -> grant it. Both -> grant the one not in last_grant. None -> stay.
- last_grant register (I/D), updated on every grant; reset value I (first conflict goes to D).
- Granted: RAM outputs follow the granted requester combinationally. ARB_I: ramREN=iREN, ramaddr=iaddr. ARB_D: ramWEN=dWEN, ramREN=dREN&~dWEN (write wins if both asserted), ramaddr=daddr, ramstore=dstore. ARB_IDLE: all RAM outputs 0.
- Completion: granted and ramstate==ACCESS -> granted wait low that cycle; next state ARB_IDLE.
- iload=ramload, dload=ramload, unconditional pass-through.
- Requester withdraws (granted REN/WEN low before ACCESS): RAM enables drop same cycle; next state ARB_IDLE; wait stays high; no arb_err.
- ramstate==ERROR while granted: wait stays high, arb_err pulses, next state ARB_IDLE; requester is re-arbitrated normally (retry).
- Timeout: cycle counter cleared on grant, increments each granted cycle without ACCESS; reaching TIMEOUT -> abort as for ERROR. TIMEOUT=0 disables it.
- Non-granted requester: wait high, inputs ignored.
- Requesters hold address/data stable while wait is high (cache protocol); no input capture.

## Timing
- Reset values: state ARB_IDLE, last_grant I, counter 0, iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, arb_err=0.
- RST mid-transaction: RAM enables drop asynchronously; in-flight access is lost, no wait deasserted.
- Grant latency: request seen in ARB_IDLE at edge N -> RAM enables asserted in cycle N+1.
- Mandatory one ARB_IDLE cycle after every completion/abort so a completed requester's stale REN is never re-granted.
- RAM with zero wait states (ACCESS in first granted cycle): one access per 2 cycles.
- arb_err registered: asserted the cycle after the ERROR/timeout cycle, for one cycle.

## Structure
- arb_state_t (ARB_IDLE, ARB_I, ARB_D) and grant_t (GNT_I, GNT_D) go in caches_types_pkg; ramstate_t and word_t come from cpu_types_pkg.
- One sub-module: arb_wdt (timeout counter, clear/enable in, expired out, parameterised by TIMEOUT).

## Test plan
- Icache only: iREN=1, iaddr=0x40, RAM ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> ramREN high 3 cycles, iwait low 1 cycle, iload=0xDEADBEEF, one idle cycle follows.
- Simultaneous: iREN and dWEN (daddr=0x80, dstore=0x1234) from reset -> D granted first (ramWEN, ramstore=0x1234), then I; next conflict grants D-then-I alternation per last_grant.
- dREN and dWEN both high -> ramWEN=1, ramREN=0.
- Withdrawal: grant I, drop iREN before ACCESS -> ramREN low same cycle, iwait stays 1, arb_err=0, state ARB_IDLE next cycle.
- ERROR then retry: ramstate=ERROR on first granted cycle -> arb_err one-cycle pulse, regrant after idle, completes on ACCESS. TIMEOUT=4 with ramstate held BUSY -> abort after 4 granted cycles, arb_err pulse.
- RST asserted mid-grant -> ramREN/ramWEN 0 and both waits 1 immediately; after release, state ARB_IDLE, last_grant I.

Source files
------------

// File: rtl/caches_types_pkg.sv
// Cache/memory-control types: arbiter state, grant owner and the round-robin pick.
package caches_types_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_I    = 2'd1,
        ARB_D    = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    // On a conflict the requester that did not win last time is served.
    function automatic grant_t pick_grant(input logic ireq, input logic dreq, input grant_t last);
        grant_t g;
        if (ireq && dreq) begin
            g = (last == GNT_I) ? GNT_D : GNT_I;
        end else if (dreq) begin
            g = GNT_D;
        end else begin
            g = GNT_I;
        end
        return g;
    endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-level types: machine word and the RAM model handshake state.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/arb_wdt.sv
// Grant watchdog: counts stalled granted cycles and flags the one that reaches TIMEOUT.
module arb_wdt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT < 32'd2) ? 1 : $clog2(TIMEOUT + 32'd1);
    localparam int unsigned LIMIT = (TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry fires during the TIMEOUT-th stalled cycle; TIMEOUT of zero never fires.
    always_comb begin
        expired = 1'b0;
        if (TIMEOUT != 32'd0) begin
            expired = en && (cnt_q == CNT_W'(LIMIT));
        end else begin
            expired = 1'b0;
        end
    end

    // Counter saturates at the limit so it can never wrap back below it.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_W'(LIMIT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between the icache and the dcache.
module mem_arbiter
    import cpu_types_pkg::*;
    import caches_types_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  ramstate_t         ramstate,
    output logic              arb_err
);

    arb_state_t state_q, state_d;
    grant_t     last_grant_q, last_grant_d;
    logic       arb_err_q, arb_err_d;

    logic dreq_s;
    logic granted_s;
    logic req_active_s;
    logic wdt_clr_s;
    logic wdt_en_s;
    logic wdt_expired_s;
    grant_t pick_s;

    assign dreq_s    = dREN | dWEN;
    assign granted_s = (state_q == ARB_I) || (state_q == ARB_D);
    assign pick_s    = pick_grant(iREN, dreq_s, last_grant_q);
    assign wdt_clr_s = ~granted_s;
    assign wdt_en_s  = granted_s && req_active_s && (ramstate != ACCESS) && (ramstate != ERROR);

    assign iload   = ramload;
    assign dload   = ramload;
    assign arb_err = arb_err_q;

    arb_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk     (CLK),
        .rst     (RST),
        .clr     (wdt_clr_s),
        .en      (wdt_en_s),
        .expired (wdt_expired_s)
    );

    // RAM port follows whichever requester holds the grant; idle drives zeros.
    always_comb begin
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = '0;
        ramstore     = '0;
        req_active_s = 1'b0;
        case (state_q)
            ARB_I: begin
                ramREN       = iREN;
                ramaddr      = iaddr;
                req_active_s = iREN;
            end
            ARB_D: begin
                ramWEN       = dWEN;
                ramREN       = dREN & ~dWEN;
                ramaddr      = daddr;
                ramstore     = dstore;
                req_active_s = dreq_s;
            end
            default: begin
                req_active_s = 1'b0;
            end
        endcase
    end

    // Arbitration, completion and abort; every grant returns through one idle cycle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        arb_err_d    = 1'b0;
        iwait        = 1'b1;
        dwait        = 1'b1;
        case (state_q)
            ARB_IDLE: begin
                if (iREN || dreq_s) begin
                    last_grant_d = pick_s;
                    state_d      = (pick_s == GNT_D) ? ARB_D : ARB_I;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_I, ARB_D: begin
                if (!req_active_s) begin
                    state_d = ARB_IDLE;
                end else if (ramstate == ACCESS) begin
                    iwait   = (state_q != ARB_I);
                    dwait   = (state_q != ARB_D);
                    state_d = ARB_IDLE;
                end else if ((ramstate == ERROR) || wdt_expired_s) begin
                    arb_err_d = 1'b1;
                    state_d   = ARB_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= GNT_I;
            arb_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            arb_err_q    <= arb_err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic against a grant-owner model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic        iwait, dwait, ramREN, ramWEN, arb_err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    ramstate_t   ramstate;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: who owns the RAM (0 none, 1 icache, 2 dcache), who won last, stall count, pending error pulse.
    int m_owner, m_last, m_gcnt;
    bit m_errp;
    bit e_iw, e_dw;

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_last  = 1;
        m_gcnt  = 0;
        m_errp  = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check all outputs, then advance the model.
    task automatic cyc(input logic i_ren, input logic [31:0] i_a, input logic d_ren, input logic d_wen,
                       input logic [31:0] d_a, input logic [31:0] d_s, input ramstate_t rs, input logic [31:0] rl);
        logic        e_ren, e_wen, active;
        logic [31:0] e_a, e_s;
        bit          nerr;
        @(negedge CLK);
        iREN = i_ren; iaddr = i_a; dREN = d_ren; dWEN = d_wen; daddr = d_a; dstore = d_s;
        ramstate = rs; ramload = rl;
        #1;
        e_ren = 1'b0; e_wen = 1'b0; e_a = 32'd0; e_s = 32'd0; active = 1'b0;
        e_iw = 1'b1; e_dw = 1'b1; nerr = 1'b0;
        if (m_owner == 1) begin
            e_ren = i_ren; e_a = i_a; active = i_ren;
        end else if (m_owner == 2) begin
            e_wen = d_wen; e_ren = d_ren && !d_wen; e_a = d_a; e_s = d_s; active = d_ren || d_wen;
        end
        if (m_owner != 0 && active && rs == ACCESS) begin
            if (m_owner == 1) e_iw = 1'b0;
            else e_dw = 1'b0;
        end
        chk("ramREN", {31'd0, ramREN}, {31'd0, e_ren});
        chk("ramWEN", {31'd0, ramWEN}, {31'd0, e_wen});
        chk("ramaddr", ramaddr, e_a);
        chk("ramstore", ramstore, e_s);
        chk("iwait", {31'd0, iwait}, {31'd0, e_iw});
        chk("dwait", {31'd0, dwait}, {31'd0, e_dw});
        chk("arb_err", {31'd0, arb_err}, {31'd0, m_errp});
        chk("iload", iload, rl);
        chk("dload", dload, rl);
        if (m_owner == 0) begin
            if (i_ren && (d_ren || d_wen)) m_owner = (m_last == 1) ? 2 : 1;
            else if (i_ren) m_owner = 1;
            else if (d_ren || d_wen) m_owner = 2;
            if (m_owner != 0) begin
                m_last = m_owner;
                m_gcnt = 0;
            end
        end else if (!active) begin
            m_owner = 0;
        end else if (rs == ACCESS) begin
            m_owner = 0;
        end else if (rs == ERROR) begin
            nerr = 1'b1; m_owner = 0;
        end else begin
            m_gcnt++;
            if (TO > 0 && m_gcnt >= TO) begin
                nerr = 1'b1; m_owner = 0;
            end
        end
        m_errp = nerr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic        ip, dp, dr, dw;
        logic [31:0] ia, da, ds;
        ramstate_t   rs;
        int          r;

        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0; ramload = 32'd0; ramstate = FREE;
        model_reset();
        @(negedge CLK); @(negedge CLK);
        #1;
        chk("rst_iwait", {31'd0, iwait}, 32'd1);
        chk("rst_dwait", {31'd0, dwait}, 32'd1);
        chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_arb_err", {31'd0, arb_err}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Icache alone: two BUSY cycles then ACCESS, REN dropped after completion.
        cyc(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        cyc(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        cyc(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        cyc(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'hDEADBEEF);
        cyc(1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);

        // Conflict: dcache write wins first, then icache; second conflict alternates.
        cyc(1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'h1234, FREE, 32'h0);
        cyc(1'b1, 32'h44, 1'b0, 1'b1, 32'h80, 32'h1234, ACCESS, 32'h0);
        cyc(1'b1, 32'h44, 1'b0, 1'b0, 32'h80, 32'h1234, FREE, 32'h0);
        cyc(1'b1, 32'h44, 1'b0, 1'b0, 32'h80, 32'h1234, ACCESS, 32'h55);
        cyc(1'b1, 32'h48, 1'b1, 1'b0, 32'h84, 32'h0, FREE, 32'h0);
        cyc(1'b1, 32'h48, 1'b1, 1'b0, 32'h84, 32'h0, ACCESS, 32'h66);
        cyc(1'b1, 32'h48, 1'b0, 1'b0, 32'h84, 32'h0, FREE, 32'h0);
        cyc(1'b1, 32'h48, 1'b0, 1'b0, 32'h84, 32'h0, ACCESS, 32'h77);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);

        // dREN and dWEN together: write wins on the RAM port.
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h90, 32'hABCD, FREE, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h90, 32'hABCD, BUSY, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h90, 32'hABCD, ACCESS, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);

        // Withdrawal before ACCESS.
        cyc(1'b1, 32'hA0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        cyc(1'b1, 32'hA0, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        cyc(1'b0, 32'hA0, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        cyc(1'b0, 32'hA0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);

        // RAM ERROR then retry to completion.
        cyc(1'b1, 32'hB0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        cyc(1'b1, 32'hB0, 1'b0, 1'b0, 32'h0, 32'h0, ERROR, 32'h0);
        cyc(1'b1, 32'hB0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        cyc(1'b1, 32'hB0, 1'b0, 1'b0, 32'h0, 32'h0, ACCESS, 32'h99);
        cyc(1'b0, 32'hB0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);

        // Timeout: BUSY held, abort after TO stalled granted cycles, then complete.
        for (int k = 0; k < TO + 3; k++)
            cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'hC0, 32'h0, BUSY, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'hC0, 32'h0, ACCESS, 32'h42);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);

        // Reset while the icache holds the grant.
        cyc(1'b1, 32'hD0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        cyc(1'b1, 32'hD0, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        #1 RST = 1'b1;
        #1;
        chk("midrst_ramREN", {31'd0, ramREN}, 32'd0);
        chk("midrst_ramWEN", {31'd0, ramWEN}, 32'd0);
        chk("midrst_iwait", {31'd0, iwait}, 32'd1);
        chk("midrst_dwait", {31'd0, dwait}, 32'd1);
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        cyc(1'b1, 32'hE0, 1'b1, 1'b0, 32'hE4, 32'h0, FREE, 32'h0);
        cyc(1'b1, 32'hE0, 1'b1, 1'b0, 32'hE4, 32'h0, ACCESS, 32'h11);
        cyc(1'b1, 32'hE0, 1'b0, 1'b0, 32'hE4, 32'h0, FREE, 32'h0);
        cyc(1'b1, 32'hE0, 1'b0, 1'b0, 32'hE4, 32'h0, ACCESS, 32'h22);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);

        // Random traffic: requesters hold their request until served.
        ip = 1'b0; dp = 1'b0; dr = 1'b0; dw = 1'b0; ia = 32'd0; da = 32'd0; ds = 32'd0;
        for (int k = 0; k < 300; k++) begin
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1'b1; ia = $urandom;
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1'b1; da = $urandom; ds = $urandom;
                dw = 1'($urandom_range(0, 1));
                dr = dw ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            r = $urandom_range(0, 9);
            if (r < 5) rs = ACCESS;
            else if (r < 8) rs = BUSY;
            else if (r < 9) rs = FREE;
            else rs = ERROR;
            cyc(ip, ia, dp & dr, dp & dw, da, ds, rs, $urandom);
            if (!e_iw) ip = 1'b0;
            if (!e_dw) dp = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
